booth_seq_mult: RTL and testbench

BOOTH_SEQ_MULT -- requirements
Module: booth_seq_mult

---
 rtl/booth_pkg.sv | 28 ++
 rtl/booth_encoder.sv | 35 +++
 rtl/booth_seq_mult.sv | 118 +++++++++++
 tb/tb_booth_seq_mult.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the radix-4 Booth sequential multiplier.
//   state_t    - controller states
//   dbg_t      - observation struct exported by the top (state + accumulator guard bits)
//   DIG_*      - radix-4 digit encodings {b[2i+1], b[2i], b[2i-1]}
package booth_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CALC = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // Guard bits are the two accumulator bits above the product width; in a
   // correct run they are pure sign/zero extension of the result.
   typedef struct packed {
      state_t     state;
      logic [1:0] acc_guard;
   } dbg_t;

   // 000 and 111 select zero and need no constant.
   localparam logic [2:0] DIG_P1_A = 3'b001;
   localparam logic [2:0] DIG_P1_B = 3'b010;
   localparam logic [2:0] DIG_P2   = 3'b011;
   localparam logic [2:0] DIG_M2   = 3'b100;
   localparam logic [2:0] DIG_M1_A = 3'b101;
   localparam logic [2:0] DIG_M1_B = 3'b110;

endpackage

// File: rtl/booth_encoder.sv
// booth_encoder: decodes one radix-4 Booth digit into multiple-select controls.
//   digit   - {b[2i+1], b[2i], b[2i-1]}
//   neg     - selected multiple is subtracted
//   sel_one - select 1*A
//   sel_two - select 2*A
//   (sel_one = sel_two = 0 means the digit contributes zero)
module booth_encoder
   import booth_pkg::*;
(
   input  logic [2:0] digit,
   output logic       neg,
   output logic       sel_one,
   output logic       sel_two
);

   always_comb begin
      neg     = 1'b0;
      sel_one = 1'b0;
      sel_two = 1'b0;
      case (digit)
         DIG_P1_A, DIG_P1_B: sel_one = 1'b1;
         DIG_P2:             sel_two = 1'b1;
         DIG_M2: begin
            neg     = 1'b1;
            sel_two = 1'b1;
         end
         DIG_M1_A, DIG_M1_B: begin
            neg     = 1'b1;
            sel_one = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/booth_seq_mult.sv
// booth_seq_mult: sequential radix-4 Booth multiplier, one digit per cycle.
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   - operand handshake (in_a, in_b, in_signed)
//   out_valid/out_ready - product handshake (out_prod, low A_W+B_W bits)
//   dbg                 - controller state and accumulator guard bits
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE, so in_valid is ignored at all other
// times. out_valid is 1 only in DONE and out_prod holds until out_ready is
// sampled high. Nothing is buffered; transactions never overlap.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter int A_W = 24,
   parameter int B_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_W-1:0]     in_a,
   input  logic [B_W-1:0]     in_b,
   input  logic               in_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [A_W+B_W-1:0] out_prod,
   output dbg_t               dbg
);

   localparam int P_W   = A_W + B_W;
   localparam int N_DIG = B_W / 2 + 1;
   localparam int CNT_W = $clog2(N_DIG);

   state_t           state, state_nxt;
   logic [A_W+1:0]   a_reg;
   logic [B_W+1:0]   b_reg;
   logic [CNT_W-1:0] cnt;
   logic [P_W+1:0]   acc, acc_nxt;
   logic [CNT_W:0]   sh_amt;
   logic [B_W+2:0]   b_aug;
   logic [2:0]       digit;
   logic             dig_neg, dig_one, dig_two;
   logic [P_W+1:0]   a_wide, mag, term;
   logic             last_dig;

   // Digit i sits at bit 2i of b_aug, whose appended LSB is the implicit b[-1] = 0.
   assign sh_amt   = {cnt, 1'b0};
   assign b_aug    = {b_reg, 1'b0};
   assign digit    = 3'(b_aug >> sh_amt);
   assign last_dig = (cnt == CNT_W'(N_DIG - 1));

   booth_encoder u_enc (
      .digit   (digit),
      .neg     (dig_neg),
      .sel_one (dig_one),
      .sel_two (dig_two)
   );

   // Single adder: the selected multiple is placed at weight 4^i and added
   // into the accumulator; carries out of P_W+2 bits are dropped.
   always_comb begin
      a_wide = {{B_W{a_reg[A_W+1]}}, a_reg};
      mag    = '0;
      if (dig_two) begin
         mag = a_wide << 1;
      end else if (dig_one) begin
         mag = a_wide;
      end
      term    = dig_neg ? -mag : mag;
      acc_nxt = acc + (term << sh_amt);
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         ST_IDLE: if (in_valid)  state_nxt = ST_CALC;
         ST_CALC: if (last_dig)  state_nxt = ST_DONE;
         ST_DONE: if (out_ready) state_nxt = ST_IDLE;
         default:                state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         a_reg <= '0;
         b_reg <= '0;
         cnt   <= '0;
         acc   <= '0;
      end else begin
         state <= state_nxt;
         case (state)
            ST_IDLE: begin
               if (in_valid) begin
                  // Two extension bits: sign copies when signed, zeros otherwise,
                  // so unsigned operands look like positive signed ones.
                  a_reg <= {{2{in_signed & in_a[A_W-1]}}, in_a};
                  b_reg <= {{2{in_signed & in_b[B_W-1]}}, in_b};
                  cnt   <= '0;
                  acc   <= '0;
               end
            end
            ST_CALC: begin
               acc <= acc_nxt;
               cnt <= cnt + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

   assign in_ready      = (state == ST_IDLE);
   assign out_valid     = (state == ST_DONE);
   assign out_prod      = acc[P_W-1:0];
   assign dbg.state     = state;
   assign dbg.acc_guard = acc[P_W+1:P_W];

endmodule

// File: tb/tb_booth_seq_mult.sv
// tb_booth_seq_mult: directed and back-to-back random checks of booth_seq_mult
// with default parameters (24 x 8 -> 32 bits).
module tb_booth_seq_mult;
   import booth_pkg::*;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] in_a;
   logic [7:0]  in_b;
   logic        in_signed;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_prod;
   dbg_t        dbg;

   int n_cmp = 0;
   int n_err = 0;

   logic [31:0] exp_q[$];

   booth_seq_mult #(.A_W(24), .B_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_signed (in_signed),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_prod  (out_prod),
      .dbg       (dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_prod(input logic [23:0] a, input logic [7:0] b, input logic s);
      logic signed [63:0] x, y, p;
      x = s ? {{40{a[23]}}, a} : {40'd0, a};
      y = s ? {{56{b[7]}}, b} : {56'd0, b};
      p = x * y;
      return p[31:0];
   endfunction

   // ---------------- driver tasks ----------------
   // Issue one operand pair with out_ready high; check latency, product and
   // that out_valid drops after one cycle.
   task automatic run_txn(input string tag, input logic [23:0] a, input logic [7:0] b,
                          input logic s, input logic [31:0] exp);
      int lat;
      @(negedge clk);
      in_a      = a;
      in_b      = b;
      in_signed = s;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
         @(posedge clk);
         #1;
         lat++;
      end
      check_eq({tag, "_latency"}, 64'(lat), 64'd6);
      check_eq({tag, "_prod"}, 64'(out_prod), 64'(exp));
      @(posedge clk);
      #1;
      check_eq({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_signed = 1'b0;
      out_ready = 1'b1;
      do_reset();

      check_eq("rst_in_ready",  64'(in_ready),  64'd1);
      check_eq("rst_out_valid", 64'(out_valid), 64'd0);
      check_eq("rst_out_prod",  64'(out_prod),  64'd0);
      check_eq("rst_state",     64'(dbg.state), 64'(ST_IDLE));

      // Directed vectors, hand-computed products.
      run_txn("u_3x5",      24'h000003, 8'h05, 1'b0, 32'h0000000F);
      run_txn("u_max",      24'hFFFFFF, 8'hFF, 1'b0, 32'hFEFFFF01);
      run_txn("s_m1xm1",    24'hFFFFFF, 8'hFF, 1'b1, 32'h00000001);
      run_txn("s_minxmin",  24'h800000, 8'h80, 1'b1, 32'h40000000);
      run_txn("s_7xm3",     24'h000007, 8'hFD, 1'b1, 32'hFFFFFFEB);
      run_txn("s_m1x127",   24'hFFFFFF, 8'h7F, 1'b1, 32'hFFFFFF81);
      run_txn("u_zero",     24'h000000, 8'hFF, 1'b0, 32'h00000000);
      run_txn("u_minxmin",  24'h800000, 8'h80, 1'b0, 32'h40000000);
      run_txn("u_shift",    24'h123456, 8'h10, 1'b0, 32'h01234560);

      // Output stall: out_ready low for 3 cycles in DONE while in_valid is
      // driven with other operands; product must hold and be taken once.
      begin
         int lat;
         @(negedge clk);
         in_a      = 24'h123456;
         in_b      = 8'h10;
         in_signed = 1'b0;
         in_valid  = 1'b1;
         out_ready = 1'b0;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         lat = 1;
         while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
         end
         check_eq("stall_latency", 64'(lat), 64'd6);
         for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 24'h000002;
            in_b     = 8'h02;
            @(posedge clk);
            #1;
            check_eq($sformatf("stall_valid_%0d", k), 64'(out_valid), 64'd1);
            check_eq($sformatf("stall_in_ready_%0d", k), 64'(in_ready), 64'd0);
            check_eq($sformatf("stall_prod_%0d", k), 64'(out_prod), 64'h01234560);
         end
         @(negedge clk);
         in_valid  = 1'b0;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         check_eq("stall_release_valid", 64'(out_valid), 64'd0);
         check_eq("stall_release_ready", 64'(in_ready), 64'd1);
         @(posedge clk);
         #1;
         check_eq("stall_no_relaunch", 64'(dbg.state), 64'(ST_IDLE));
      end

      // Reset during the third CALC cycle aborts the transaction.
      begin
         int seen;
         @(negedge clk);
         in_a      = 24'h000003;
         in_b      = 8'h05;
         in_signed = 1'b0;
         in_valid  = 1'b1;
         out_ready = 1'b1;
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         @(posedge clk);
         @(posedge clk);
         #1;
         check_eq("abort_in_calc", 64'(dbg.state), 64'(ST_CALC));
         @(negedge clk);
         rst = 1'b1;
         @(posedge clk);
         #1;
         check_eq("abort_state",     64'(dbg.state), 64'(ST_IDLE));
         check_eq("abort_in_ready",  64'(in_ready),  64'd1);
         check_eq("abort_out_valid", 64'(out_valid), 64'd0);
         check_eq("abort_out_prod",  64'(out_prod),  64'd0);
         @(negedge clk);
         rst  = 1'b0;
         seen = 0;
         for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
         end
         check_eq("abort_no_output", 64'(seen), 64'd0);
         run_txn("after_abort", 24'h000007, 8'hFD, 1'b1, 32'hFFFFFFEB);
      end

      // Back-to-back: in_valid and out_ready held high, 100 random pairs.
      begin
         int sent, rcv, cyc, last_cyc, guard;
         sent     = 0;
         rcv      = 0;
         cyc      = 0;
         last_cyc = -1;
         guard    = 0;
         out_ready = 1'b1;
         fork
            begin : drv
               while (sent < 100 && guard < 3000) begin
                  @(negedge clk);
                  guard++;
                  if (in_ready) begin
                     in_a      = 24'($urandom_range(0, 32'h00FFFFFF));
                     in_b      = 8'($urandom_range(0, 255));
                     in_signed = 1'($urandom_range(0, 1));
                     in_valid  = 1'b1;
                     exp_q.push_back(ref_prod(in_a, in_b, in_signed));
                     sent++;
                  end
               end
               @(negedge clk);
               in_valid = 1'b0;
            end
            begin : mon
               while (rcv < 100 && cyc < 3000) begin
                  @(posedge clk);
                  #1;
                  cyc++;
                  if (out_valid) begin
                     if (exp_q.size() == 0) begin
                        check_eq("b2b_unexpected", 64'(out_prod), 64'hDEAD);
                     end else begin
                        check_eq($sformatf("b2b_prod_%0d", rcv), 64'(out_prod), 64'(exp_q.pop_front()));
                     end
                     if (last_cyc >= 0) begin
                        check_eq($sformatf("b2b_interval_%0d", rcv), 64'(cyc - last_cyc), 64'd7);
                     end
                     last_cyc = cyc;
                     rcv++;
                  end
               end
            end
         join
         check_eq("b2b_sent",     64'(sent), 64'd100);
         check_eq("b2b_received", 64'(rcv),  64'd100);
         check_eq("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
      end

      // ---------------- final report ----------------
      repeat (2) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
